draw_player: RTL and testbench
==============================

// Module: draw_player
// PURPOSE
//  VGA pipeline stage placed directly downstream of the start screen overlay.
//  Draws the player as a solid rectangle over the incoming pixel stream.
//  Runs a per-frame jump FSM (ground/rise/fall) under constant gravity.
//  Forwards every other bus field unchanged, delayed by one cycle.
// PARAMETERS
//  XPOS     100     left column of the player, px
//  WIDTH    32      player width, px
//  HEIGHT   32      player height, px
//  GROUND_Y 500     top row of the player when standing
//  JUMP_V   16      initial upward speed, px/frame
//  GRAVITY  1       speed decrement per frame
//  MAX_FALL 16      downward speed cap, px/frame
//  COLOR    12'hF80 player RGB444
// PORTS
//  clk         in  1              pixel clock
//  rst         in  1              synchronous, active-high reset
//  module_en   in  1              1 = game running; 0 = pass-through, FSM held
//  jump        in  1              jump request; level or pulse, sampled each cycle
//  vga_bus_in  in  VGA_BUS_SIZE   hcount[10:0], vcount[10:0], hsync, vsync, rgb[11:0]
//  vga_bus_out out VGA_BUS_SIZE   same fields, 1-cycle latency
//  player_y    out 11             current top row of the player
//  landed      out 1              1-cycle pulse when the player touches ground
// BEHAVIOUR
//  Reset: all bus output fields 0, player_y=GROUND_Y, vel=0, state GROUND,
//   landed=0, jump_pend=0, vsync_d=0.
//  Bus: hcount/vcount/hsync/vsync are registered straight through.
//   rgb_out <= COLOR if module_en && XPOS<=hcount_in<XPOS+WIDTH
//   && player_y<=vcount_in<player_y+HEIGHT; otherwise rgb_out <= rgb_in.
//   Bounds are half-open; compares use 12-bit unsigned (no wrap at 2047).
//  Frame tick: vsync_in rising edge, i.e. vsync_in && !vsync_d. This is the
//   only cycle in which player_y, vel or state may change, so no tearing.
//  jump_pend: set by jump in GROUND; cleared on every tick; never set in RISE/FALL.
//   A jump in the same cycle as the tick is captured for the next tick.
//  vel: signed 8-bit, positive = up. Arithmetic is on 12-bit signed
//   y_nxt = player_y - sext(vel).
//  FSM, evaluated on tick only:
//   GROUND: if jump_pend -> RISE, vel=JUMP_V-GRAVITY, y=GROUND_Y-JUMP_V.
//   RISE:   y=y_nxt; vel_nxt=vel-GRAVITY; if vel_nxt<=0 -> FALL.
//           If y_nxt<0: y=0, vel=0, -> FALL (ceiling).
//   FALL:   y=y_nxt; vel=max(vel-GRAVITY,-MAX_FALL).
//           If y_nxt>=GROUND_Y: y=GROUND_Y, vel=0, landed=1, -> GROUND.
//  module_en=0: rgb passes through. State is forced to GROUND, y=GROUND_Y,
//   vel=0, jump_pend=0, landed=0, synchronously and regardless of tick.
//  rst asserted mid-jump: reset values on the next edge; no landed pulse.
// STRUCTURE
//  Bus field widths and split/merge macros come from macros.vh.
//  Add to macros.vh: state encodings (ST_GROUND=2'd0, ST_RISE=2'd1, ST_FALL=2'd2).
//  One sub-module, player_physics: tick, jump and enable in; player_y, landed and
//   state out. The top level keeps the pixel compare and bus registers.
// TESTING
//  Reset, then 3 frames with module_en=1 and no jump: player_y=500. Pixel (100,500)
//   gives COLOR; pixels (132,500) and (99,500) give rgb_in; output lags input by 1 cycle.
//  Single jump pulse in frame 0. After tick 1: y=484, state RISE. After tick 16:
//   y=364, state FALL. Tick 33: y=500, landed=1 for exactly one cycle, state GROUND.
//  Jump held high throughout the flight: no re-jump before landing. A new jump starts
//   on the first tick after landing (tick 34: y=484).
//  JUMP_V=40, GROUND_Y=100: the ceiling is hit. Required: y=0, vel=0, state FALL,
//   no underflow.
//  Drop module_en at tick 10: y=500 and state GROUND next cycle, rgb equals rgb_in,
//   no landed pulse.
//  Assert rst during FALL (y=400): all outputs take reset values on the next edge,
//   and the bus is zero for one cycle.

Source files
------------

// File: rtl/draw_player_pkg.sv
// Shared types and helpers for the player overlay stage.
package draw_player_pkg;

  localparam int unsigned COORD_W      = 11;
  localparam int unsigned RGB_W        = 12;
  localparam int unsigned VEL_W        = 8;
  localparam int unsigned VGA_BUS_SIZE = 2 * COORD_W + 2 + RGB_W;

  // Pixel bus payload, MSB first: hcount, vcount, hsync, vsync, rgb.
  typedef struct packed {
    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic [RGB_W-1:0]   rgb;
  } vga_bus_t;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } player_state_e;

  // Half-open span test lo <= val < lo+len, widened by one bit so the top edge never wraps.
  function automatic logic in_span(input logic [COORD_W-1:0] val,
                                   input logic [COORD_W:0]   lo,
                                   input logic [COORD_W:0]   len);
    logic [COORD_W:0] v;
    v = {1'b0, val};
    return (v >= lo) && (v < (lo + len));
  endfunction

endpackage

// File: rtl/draw_player_physics.sv
// Per-frame jump state machine: vertical position and velocity under gravity.
module draw_player_physics
  import draw_player_pkg::*;
#(
  parameter int unsigned GROUND_Y = 500,
  parameter int unsigned JUMP_V   = 16,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned MAX_FALL = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               tick,
  input  logic               jump,
  output logic [COORD_W-1:0] player_y,
  output logic               landed,
  output player_state_e      state
);

  localparam logic signed [VEL_W-1:0]   GRAV_S   = VEL_W'(GRAVITY);
  localparam logic signed [VEL_W-1:0]   FALL_CAP = VEL_W'(0) - VEL_W'(MAX_FALL);
  localparam logic signed [VEL_W-1:0]   LAUNCH_V = VEL_W'(JUMP_V - GRAVITY);
  localparam logic        [COORD_W-1:0] GROUND   = COORD_W'(GROUND_Y);
  localparam logic        [COORD_W-1:0] LAUNCH_Y = COORD_W'(GROUND_Y - JUMP_V);
  localparam logic signed [COORD_W:0]   GROUND_S = (COORD_W + 1)'(GROUND_Y);

  player_state_e           state_q, state_nxt;
  logic [COORD_W-1:0]      y_q, y_nxt;
  logic signed [VEL_W-1:0] vel_q, vel_nxt;
  logic                    pend_q, pend_nxt;
  logic                    landed_q, landed_nxt;
  logic signed [COORD_W:0] y_step;
  logic signed [VEL_W-1:0] vel_dec;

  // Candidate position one velocity step on, and the gravity-decayed velocity.
  assign y_step  = $signed({1'b0, y_q}) - $signed({{(COORD_W + 1 - VEL_W){vel_q[VEL_W-1]}}, vel_q});
  assign vel_dec = vel_q - GRAV_S;

  // Next-state logic; motion only advances on the frame tick so a frame never tears.
  always_comb begin
    state_nxt  = state_q;
    y_nxt      = y_q;
    vel_nxt    = vel_q;
    pend_nxt   = pend_q | (jump && (state_q == ST_GROUND));
    landed_nxt = 1'b0;
    if (!enable) begin
      state_nxt = ST_GROUND;
      y_nxt     = GROUND;
      vel_nxt   = '0;
      pend_nxt  = 1'b0;
    end else if (tick) begin
      case (state_q)
        ST_GROUND: begin
          if (pend_q) begin
            state_nxt = ST_RISE;
            vel_nxt   = LAUNCH_V;
            y_nxt     = LAUNCH_Y;
          end
        end
        ST_RISE: begin
          if (y_step < 12'sd0) begin
            y_nxt     = '0;
            vel_nxt   = '0;
            state_nxt = ST_FALL;
          end else begin
            y_nxt   = y_step[COORD_W-1:0];
            vel_nxt = vel_dec;
            if (vel_dec <= 8'sd0) state_nxt = ST_FALL;
          end
        end
        ST_FALL: begin
          if (y_step >= GROUND_S) begin
            y_nxt      = GROUND;
            vel_nxt    = '0;
            landed_nxt = 1'b1;
            state_nxt  = ST_GROUND;
          end else begin
            y_nxt   = y_step[COORD_W-1:0];
            vel_nxt = (vel_dec < FALL_CAP) ? FALL_CAP : vel_dec;
          end
        end
        default: begin
          state_nxt = ST_GROUND;
          y_nxt     = GROUND;
          vel_nxt   = '0;
        end
      endcase
      // A request arriving on the tick itself is kept for the following tick.
      pend_nxt = jump && (state_q == ST_GROUND) && (state_nxt == ST_GROUND);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_GROUND;
      y_q      <= GROUND;
      vel_q    <= '0;
      pend_q   <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      y_q      <= y_nxt;
      vel_q    <= vel_nxt;
      pend_q   <= pend_nxt;
      landed_q <= landed_nxt;
    end
  end

  assign player_y = y_q;
  assign landed   = landed_q;
  assign state    = state_q;

endmodule

// File: rtl/draw_player.sv
// Pixel pipeline stage that paints the player rectangle and runs its jump physics.
module draw_player
  import draw_player_pkg::*;
#(
  parameter int unsigned      XPOS     = 100,
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      HEIGHT   = 32,
  parameter int unsigned      GROUND_Y = 500,
  parameter int unsigned      JUMP_V   = 16,
  parameter int unsigned      GRAVITY  = 1,
  parameter int unsigned      MAX_FALL = 16,
  parameter logic [RGB_W-1:0] COLOR    = 12'hF80
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    module_en,
  input  logic                    jump,
  input  logic [VGA_BUS_SIZE-1:0] vga_bus_in,
  output logic [VGA_BUS_SIZE-1:0] vga_bus_out,
  output logic [COORD_W-1:0]      player_y,
  output logic                    landed
);

  vga_bus_t      bus_in, bus_q;
  logic          vsync_d;
  logic          frame_tick;
  logic          draw;
  player_state_e phys_state;

  assign bus_in      = vga_bus_in;
  assign vga_bus_out = bus_q;
  assign frame_tick  = bus_in.vsync && !vsync_d;

  assign draw = module_en
             && in_span(bus_in.hcount, (COORD_W + 1)'(XPOS), (COORD_W + 1)'(WIDTH))
             && in_span(bus_in.vcount, {1'b0, player_y}, (COORD_W + 1)'(HEIGHT));

  draw_player_physics #(
    .GROUND_Y (GROUND_Y),
    .JUMP_V   (JUMP_V),
    .GRAVITY  (GRAVITY),
    .MAX_FALL (MAX_FALL)
  ) u_physics (
    .clk      (clk),
    .rst      (rst),
    .enable   (module_en),
    .tick     (frame_tick),
    .jump     (jump),
    .player_y (player_y),
    .landed   (landed),
    .state    (phys_state)
  );

  // One-cycle bus register with the sprite colour substituted inside the rectangle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q   <= '0;
      vsync_d <= 1'b0;
    end else begin
      bus_q.hcount <= bus_in.hcount;
      bus_q.vcount <= bus_in.vcount;
      bus_q.hsync  <= bus_in.hsync;
      bus_q.vsync  <= bus_in.vsync;
      bus_q.rgb    <= draw ? COLOR : bus_in.rgb;
      vsync_d      <= bus_in.vsync;
    end
  end

endmodule

// File: tb/tb_draw_player.sv
// Directed bench for draw_player: drawing, jump arc, ceiling, enable drop, reset.
module tb_draw_player;
  import draw_player_pkg::*;

  logic clk = 1'b0;
  logic rst, module_en, jump, jump2;
  logic [10:0] hc, vc;
  logic hs, vs;
  logic [11:0] rgb_in;
  logic [VGA_BUS_SIZE-1:0] bus_in, bus_out, bus_out2;
  logic [10:0] py, py2;
  logic ld, ld2;
  logic ld_tick;
  vga_bus_t ob;
  int checks = 0;
  int failures = 0;

  assign bus_in = {hc, vc, hs, vs, rgb_in};
  assign ob     = bus_out;

  always #5 clk = ~clk;

  draw_player dut (
    .clk(clk), .rst(rst), .module_en(module_en), .jump(jump),
    .vga_bus_in(bus_in), .vga_bus_out(bus_out), .player_y(py), .landed(ld)
  );

  draw_player #(.GROUND_Y(100), .JUMP_V(40)) dut2 (
    .clk(clk), .rst(rst), .module_en(module_en), .jump(jump2),
    .vga_bus_in(bus_in), .vga_bus_out(bus_out2), .player_y(py2), .landed(ld2)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // One frame: vsync high for a cycle (the tick edge), then low.
  task automatic do_tick;
    vs = 1'b1;
    cyc();
    ld_tick = ld;
    vs = 1'b0;
    cyc();
  endtask

  task automatic test_reset;
    rst = 1'b1; module_en = 1'b1; jump = 1'b0; jump2 = 1'b0;
    hc = 11'd5; vc = 11'd6; hs = 1'b1; vs = 1'b0; rgb_in = 12'h123;
    cyc(); cyc();
    checks++; if (bus_out !== 36'h0) begin failures++; $display("FAIL reset_bus: got %h expected 0", bus_out); end
    checks++; if (bus_out2 !== 36'h0) begin failures++; $display("FAIL reset_bus2: got %h expected 0", bus_out2); end
    checks++; if (py !== 11'd500) begin failures++; $display("FAIL reset_y: got %0d expected 500", py); end
    checks++; if (py2 !== 11'd100) begin failures++; $display("FAIL reset_y2: got %0d expected 100", py2); end
    checks++; if (ld !== 1'b0) begin failures++; $display("FAIL reset_landed: got %b expected 0", ld); end
    checks++; if (dut.phys_state !== ST_GROUND) begin failures++; $display("FAIL reset_state: got %0d expected 0", dut.phys_state); end
    rst = 1'b0;
  endtask

  task automatic test_idle_draw;
    logic [10:0] ph [6];
    logic [10:0] pv [6];
    logic        pin [6];
    logic [11:0] exp_rgb;
    ph = '{11'd100, 11'd132, 11'd99, 11'd131, 11'd100, 11'd100};
    pv = '{11'd500, 11'd500, 11'd500, 11'd531, 11'd532, 11'd499};
    pin = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    hs = 1'b0;
    for (int f = 0; f < 3; f++) begin
      do_tick();
      checks++; if (py !== 11'd500) begin failures++; $display("FAIL idle_y%0d: got %0d expected 500", f, py); end
    end
    for (int i = 0; i < 6; i++) begin
      hc = ph[i]; vc = pv[i]; rgb_in = 12'h0A0 + 12'(i);
      exp_rgb = pin[i] ? 12'hF80 : rgb_in;
      cyc();
      checks++; if (ob.rgb !== exp_rgb) begin failures++; $display("FAIL pix%0d_rgb: got %h expected %h", i, ob.rgb, exp_rgb); end
      checks++; if (ob.hcount !== ph[i] || ob.vcount !== pv[i]) begin failures++; $display("FAIL pix%0d_coord: got %0d,%0d expected %0d,%0d", i, ob.hcount, ob.vcount, ph[i], pv[i]); end
    end
    // New input must not appear before the next edge.
    hc = 11'd100; vc = 11'd500; hs = 1'b1; rgb_in = 12'h055;
    #1;
    checks++; if (ob.rgb !== 12'h0A5 || ob.hsync !== 1'b0) begin failures++; $display("FAIL latency_hold: got rgb %h hs %b expected 0a5 0", ob.rgb, ob.hsync); end
    cyc();
    checks++; if (ob.rgb !== 12'hF80 || ob.hsync !== 1'b1) begin failures++; $display("FAIL latency_new: got rgb %h hs %b expected f80 1", ob.rgb, ob.hsync); end
    hs = 1'b0;
  endtask

  task automatic test_ceiling;
    jump2 = 1'b1; cyc(); jump2 = 1'b0;
    do_tick();
    checks++; if (py2 !== 11'd60 || dut2.phys_state !== ST_RISE) begin failures++; $display("FAIL ceil_t1: got y %0d st %0d expected 60 1", py2, dut2.phys_state); end
    do_tick();
    checks++; if (py2 !== 11'd21) begin failures++; $display("FAIL ceil_t2: got %0d expected 21", py2); end
    do_tick();
    checks++; if (py2 !== 11'd0) begin failures++; $display("FAIL ceil_y: got %0d expected 0", py2); end
    checks++; if (dut2.u_physics.vel_q !== 8'sd0) begin failures++; $display("FAIL ceil_vel: got %0d expected 0", dut2.u_physics.vel_q); end
    checks++; if (dut2.phys_state !== ST_FALL) begin failures++; $display("FAIL ceil_state: got %0d expected 2", dut2.phys_state); end
  endtask

  task automatic test_jump;
    int early;
    early = 0;
    jump = 1'b1; cyc(); jump = 1'b0;
    for (int t = 1; t <= 33; t++) begin
      do_tick();
      if (t < 33 && (ld_tick || ld)) early++;
      if (t == 1) begin
        checks++; if (py !== 11'd484 || dut.phys_state !== ST_RISE) begin failures++; $display("FAIL jump_t1: got y %0d st %0d expected 484 1", py, dut.phys_state); end
      end
      if (t == 16) begin
        checks++; if (py !== 11'd364 || dut.phys_state !== ST_FALL) begin failures++; $display("FAIL jump_t16: got y %0d st %0d expected 364 2", py, dut.phys_state); end
        hc = 11'd100; vc = 11'd364; rgb_in = 12'h00F; cyc();
        checks++; if (ob.rgb !== 12'hF80) begin failures++; $display("FAIL apex_top: got %h expected f80", ob.rgb); end
        vc = 11'd363; cyc();
        checks++; if (ob.rgb !== 12'h00F) begin failures++; $display("FAIL apex_above: got %h expected 00f", ob.rgb); end
      end
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL jump_early_land: got %0d expected 0", early); end
    checks++; if (ld_tick !== 1'b1) begin failures++; $display("FAIL land_pulse: got %b expected 1", ld_tick); end
    checks++; if (ld !== 1'b0) begin failures++; $display("FAIL land_width: got %b expected 0", ld); end
    checks++; if (py !== 11'd500 || dut.phys_state !== ST_GROUND) begin failures++; $display("FAIL land_t33: got y %0d st %0d expected 500 0", py, dut.phys_state); end
  endtask

  task automatic test_jump_held;
    int regnd;
    regnd = 0;
    jump = 1'b1; cyc();
    for (int t = 1; t <= 34; t++) begin
      do_tick();
      if (t < 33 && dut.phys_state === ST_GROUND) regnd++;
      if (t == 33) begin
        checks++; if (py !== 11'd500 || ld_tick !== 1'b1) begin failures++; $display("FAIL held_t33: got y %0d ld %b expected 500 1", py, ld_tick); end
      end
    end
    checks++; if (regnd !== 0) begin failures++; $display("FAIL held_rejump: got %0d expected 0", regnd); end
    checks++; if (py !== 11'd484 || dut.phys_state !== ST_RISE) begin failures++; $display("FAIL held_t34: got y %0d st %0d expected 484 1", py, dut.phys_state); end
    jump = 1'b0;
  endtask

  task automatic test_enable_drop;
    module_en = 1'b0; cyc(); module_en = 1'b1;
    checks++; if (py !== 11'd500 || dut.phys_state !== ST_GROUND) begin failures++; $display("FAIL en_clear: got y %0d st %0d expected 500 0", py, dut.phys_state); end
    jump = 1'b1; cyc(); jump = 1'b0;
    for (int t = 1; t <= 9; t++) do_tick();
    checks++; if (py !== 11'd392) begin failures++; $display("FAIL en_t9: got %0d expected 392", py); end
    module_en = 1'b0; vs = 1'b1; hc = 11'd110; vc = 11'd400; rgb_in = 12'h3C3;
    cyc();
    checks++; if (py !== 11'd500 || dut.phys_state !== ST_GROUND) begin failures++; $display("FAIL en_drop: got y %0d st %0d expected 500 0", py, dut.phys_state); end
    checks++; if (ob.rgb !== 12'h3C3) begin failures++; $display("FAIL en_rgb: got %h expected 3c3", ob.rgb); end
    vs = 1'b0; cyc();
    checks++; if (ld !== 1'b0) begin failures++; $display("FAIL en_landed: got %b expected 0", ld); end
    module_en = 1'b1;
    do_tick();
    checks++; if (py !== 11'd500 || dut.phys_state !== ST_GROUND || ld_tick !== 1'b0) begin failures++; $display("FAIL en_resume: got y %0d st %0d ld %b expected 500 0 0", py, dut.phys_state, ld_tick); end
  endtask

  task automatic test_rst_fall;
    jump = 1'b1; cyc(); jump = 1'b0;
    for (int t = 1; t <= 25; t++) do_tick();
    checks++; if (py !== 11'd400 || dut.phys_state !== ST_FALL) begin failures++; $display("FAIL fall_t25: got y %0d st %0d expected 400 2", py, dut.phys_state); end
    rst = 1'b1; vs = 1'b1; hs = 1'b1; hc = 11'd7; vc = 11'd9; rgb_in = 12'hABC;
    cyc();
    checks++; if (bus_out !== 36'h0) begin failures++; $display("FAIL rst_bus: got %h expected 0", bus_out); end
    checks++; if (py !== 11'd500 || ld !== 1'b0 || dut.phys_state !== ST_GROUND) begin failures++; $display("FAIL rst_phys: got y %0d ld %b st %0d expected 500 0 0", py, ld, dut.phys_state); end
    rst = 1'b0; vs = 1'b0;
    cyc();
    checks++; if (ob.hcount !== 11'd7 || ob.rgb !== 12'hABC || ob.hsync !== 1'b1) begin failures++; $display("FAIL rst_release: got h %0d rgb %h hs %b expected 7 abc 1", ob.hcount, ob.rgb, ob.hsync); end
    checks++; if (ld !== 1'b0) begin failures++; $display("FAIL rst_landed: got %b expected 0", ld); end
  endtask

  initial begin
    test_reset();
    test_idle_draw();
    test_ceiling();
    test_jump();
    test_jump_held();
    test_enable_drop();
    test_rst_fall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
